// File: rtl/output_interface_pkg.sv
// Shared NoC router definitions: default packet width, one-hot output port ids
// and packet field positions also used by routing_algo.
package output_interface_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;

  // One-hot output port identifiers
  localparam logic [4:0] DIR_L  = 5'b10000;
  localparam logic [4:0] DIR_R  = 5'b01000;
  localparam logic [4:0] DIR_U  = 5'b00100;
  localparam logic [4:0] DIR_D  = 5'b00010;
  localparam logic [4:0] DIR_PE = 5'b00001;

  // Packet header fields (destination coordinates in the top bits)
  localparam int unsigned PKT_DST_X_MSB = 63;
  localparam int unsigned PKT_DST_X_LSB = 60;
  localparam int unsigned PKT_DST_Y_MSB = 59;
  localparam int unsigned PKT_DST_Y_LSB = 56;

  // Number of requesting input interfaces per output port
  localparam int unsigned NUM_REQ = 4;

endpackage

// File: rtl/output_interface_if.sv
// Bundle between the four input interfaces, one output port and the downstream
// receiver.
//  req_k/data_k   : request and packet from input interface k (k=1..4)
//  buf_clear_k    : one-cycle clear back to input interface k
//  so/datao       : send strobe and packet to the next router or PE
//  ro             : downstream ready
// Modport slave is the output port block, master is everything around it.
interface output_interface_if #(
  parameter int unsigned DATA_WIDTH = output_interface_pkg::DATA_WIDTH_DEF
);
  logic                  req_1, req_2, req_3, req_4;
  logic [DATA_WIDTH-1:0] data_1, data_2, data_3, data_4;
  logic                  buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4;
  logic                  so;
  logic                  ro;
  logic [DATA_WIDTH-1:0] datao;

  modport slave (
    input  req_1, req_2, req_3, req_4,
    input  data_1, data_2, data_3, data_4,
    input  ro,
    output buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
    output so, datao
  );

  modport master (
    output req_1, req_2, req_3, req_4,
    output data_1, data_2, data_3, data_4,
    output ro,
    input  buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
    input  so, datao
  );
endinterface

// File: rtl/output_interface_rr_arbiter4.sv
// Four-way round-robin arbiter, pure combinational.
//  req     : request vector, bit i = input interface i+1
//  ptr     : last granted input number modulo 4, so the search starts at bit ptr
//  en      : grant enable (buffer can accept)
//  gnt     : one-hot grant, zero when en=0 or no request
//  gnt_idx : index of the granted bit (valid when gnt != 0)
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/output_interface.sv
// One router output port: round-robin picks one of four input requests, clears
// the winner's input channel and holds the packet in a 1-entry buffer that is
// sent downstream over the so/ro handshake. Drain and refill may share an edge.
//  clk, rst : clock and asynchronous active-high reset
//  bus      : request/data/clear bundle plus so/ro/datao (slave side)
module output_interface
  import output_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [4:0]  DIRECTION  = DIR_L,
  parameter logic [1:0]  PTR_INIT   = 2'd0
) (
  input  logic               clk,
  input  logic               rst,
  output_interface_if.slave  bus
);

  if (!$onehot(DIRECTION)) begin : g_bad_direction
    $error("output_interface: DIRECTION must be one-hot");
  end

  logic                  so_q;
  logic [DATA_WIDTH-1:0] datao_q;
  logic [1:0]            ptr_q;

  logic                  acc;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    buf_clear;
  logic [1:0]            gnt_idx;
  logic [DATA_WIDTH-1:0] data_sel;

  assign req = {bus.req_4, bus.req_3, bus.req_2, bus.req_1};

  // Gated by rst so no clear leaks out while the block is held in reset
  assign acc = ~rst & (~so_q | bus.ro);

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .en      (acc),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign buf_clear       = gnt & {NUM_REQ{acc}};
  assign bus.buf_clear_1 = buf_clear[0];
  assign bus.buf_clear_2 = buf_clear[1];
  assign bus.buf_clear_3 = buf_clear[2];
  assign bus.buf_clear_4 = buf_clear[3];

  always_comb begin
    data_sel = '0;
    unique case (gnt_idx)
      2'd0: data_sel = bus.data_1;
      2'd1: data_sel = bus.data_2;
      2'd2: data_sel = bus.data_3;
      2'd3: data_sel = bus.data_4;
      default: data_sel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      so_q    <= 1'b0;
      datao_q <= '0;
      ptr_q   <= PTR_INIT;
    end else if (|buf_clear) begin
      so_q    <= 1'b1;
      datao_q <= data_sel;
      // Pointer holds input number k mod 4, i.e. next search starts after k
      ptr_q   <= gnt_idx + 2'd1;
    end else if (so_q && bus.ro) begin
      so_q    <= 1'b0;
    end
  end

  assign bus.so    = so_q;
  assign bus.datao = datao_q;

endmodule

// File: tb/tb_output_interface.sv
module tb_output_interface;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] D4 = 64'hFFFF_0000_FFFF_0004;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  output_interface_if #(.DATA_WIDTH(64)) bus ();

  output_interface #(
    .DATA_WIDTH (64),
    .DIRECTION  (5'b10000),
    .PTR_INIT   (2'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] clears();
    return 64'({bus.buf_clear_4, bus.buf_clear_3, bus.buf_clear_2, bus.buf_clear_1});
  endfunction

  task automatic set_req(input logic [3:0] r);
    bus.req_1 = r[0];
    bus.req_2 = r[1];
    bus.req_3 = r[2];
    bus.req_4 = r[3];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.data_1  = D1;
    bus.data_2  = D2;
    bus.data_3  = D3;
    bus.data_4  = D4;
    bus.ro      = 1'b1;
    rst         = 1'b1;
    set_req(4'b0010);

    // Reset state; a pending request must not be cleared during reset
    tick();
    check("rst_so", 64'(bus.so), 64'd0);
    check("rst_datao", bus.datao, 64'd0);
    check("rst_clear", clears(), 64'd0);
    rst = 1'b0;
    #1;

    // Single request on input 2
    check("single_clear", clears(), 64'b0010);
    tick();
    set_req(4'b0000);
    check("single_so", 64'(bus.so), 64'd1);
    check("single_datao", bus.datao, D2);

    // Drain to empty, then req_4 fills on the next edge
    tick();
    check("drain_so", 64'(bus.so), 64'd0);
    set_req(4'b1000);
    check("req4_clear", clears(), 64'b1000);
    tick();
    set_req(4'b0000);
    check("req4_so", 64'(bus.so), 64'd1);
    check("req4_datao", bus.datao, D4);

    // Round robin with all four held, ptr=0: grants 1,2,3,4,1
    set_req(4'b1111);
    for (int i = 0; i < 5; i++) begin
      logic [63:0] exp_d;
      int          k;
      k = i % 4;
      exp_d = (k == 0) ? D1 : (k == 1) ? D2 : (k == 2) ? D3 : D4;
      check($sformatf("rr_clear_%0d", i), clears(), 64'(1) << k);
      tick();
      check($sformatf("rr_datao_%0d", i), bus.datao, exp_d);
      check($sformatf("rr_so_%0d", i), 64'(bus.so), 64'd1);
    end
    set_req(4'b0000);

    // Backpressure: full with D1, ro=0 for 5 cycles, req_3 waits
    bus.ro = 1'b0;
    set_req(4'b0100);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_clear_%0d", i), clears(), 64'd0);
      tick();
      check($sformatf("bp_datao_%0d", i), bus.datao, D1);
      check($sformatf("bp_so_%0d", i), 64'(bus.so), 64'd1);
    end
    bus.ro = 1'b1;
    #1;
    check("bp_release_clear", clears(), 64'b0100);
    tick();
    set_req(4'b0000);
    check("bp_new_datao", bus.datao, D3);

    // Wrap: ptr=3, req_1 and req_3 -> input 1 first, then input 3
    set_req(4'b0101);
    check("wrap_clear_1", clears(), 64'b0001);
    tick();
    check("wrap_datao_1", bus.datao, D1);
    set_req(4'b0100);
    check("wrap_clear_3", clears(), 64'b0100);
    tick();
    set_req(4'b0000);
    check("wrap_datao_3", bus.datao, D3);
    check("wrap_so", 64'(bus.so), 64'd1);

    // Async reset between edges while full
    bus.ro = 1'b0;
    set_req(4'b0010);
    #1;
    rst = 1'b1;
    #1;
    check("arst_so", 64'(bus.so), 64'd0);
    check("arst_datao", bus.datao, 64'd0);
    check("arst_clear", clears(), 64'd0);
    rst = 1'b0;
    set_req(4'b1111);
    // ptr back to 0 -> input 1 wins
    check("arst_first_clear", clears(), 64'b0001);
    tick();
    set_req(4'b0000);
    check("arst_first_datao", bus.datao, D1);
    check("arst_first_so", 64'(bus.so), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
